// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment scan controller: FSM states,
// the dark-segment constant and the active-low hex glyph table.
// Segment bit order is {g,f,e,d,c,b,a}; a 0 bit lights the segment.
package seg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } scan_state_e;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Index n holds the glyph for hex digit n (entry 15 is listed first).
   localparam logic [15:0][6:0] HEX_GLYPH = {
      7'h0E, 7'h06, 7'h21, 7'h46,   // F E D C
      7'h03, 7'h08, 7'h10, 7'h00,   // B A 9 8
      7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
      7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
   };

endpackage

// File: rtl/seg_scan_ctrl_hex_enc.sv
// Combinational hex-to-seven-segment encoder (active-low outputs).
module seg_scan_ctrl_hex_enc
   import seg_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg_n
);

   // Table lookup of the glyph for one hex nibble.
   always_comb begin
      seg_n = HEX_GLYPH[nib];
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode display.
// Each digit slot is SLOT_CYC cycles: BLANK_CYC dark cycles (anti-ghosting)
// followed by the lit SHOW part. New values are taken into a shadow register
// only at frame boundaries (entry into BLANK for digit 0), so one frame never
// mixes old and new digits. In IDLE a value offer is accepted immediately.
//
// value_vld/value_ack: the producer raises value_vld with value stable and
// holds both until it sees value_ack, a single-cycle pulse on the edge the
// shadow register loads. Ack never fires on two consecutive cycles; a vld
// still high after an ack counts as a fresh offer.
//
// Optional build macro SEG_SCAN_LZB_EN: leading-zero blanking of digits k>0.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int N_DIGITS  = 4,
   parameter int SLOT_CYC  = 50000,
   parameter int BLANK_CYC = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic [4*N_DIGITS-1:0]   value,
   input  logic [N_DIGITS-1:0]     dp_in,
   input  logic                    value_vld,
   output logic                    value_ack,
   output logic [6:0]              seg_n,
   output logic                    dp_n,
   output logic [N_DIGITS-1:0]     an_n,
   output logic                    frame_tick
);

   localparam int CNT_W = $clog2(SLOT_CYC);
   localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SLOT_CYC - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

   scan_state_e               state_q, state_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [4*N_DIGITS-1:0]     shadow_q, shadow_d;
   logic                      ack_q, ack_d;
   logic                      tick_q, tick_d;
   logic [6:0]                seg_q, seg_d;
   logic                      dp_q, dp_d;
   logic [N_DIGITS-1:0]       an_q, an_d;

   logic                      boundary;
   logic [3:0]                enc_nib;
   logic [6:0]                enc_seg;
   logic [N_DIGITS-1:0]       lz_mask;

   // The single shared encoder sees the shadow nibble of the current digit.
   assign enc_nib = shadow_q[{idx_q, 2'b00} +: 4];

   seg_scan_ctrl_hex_enc u_hex_enc (
      .nib   (enc_nib),
      .seg_n (enc_seg)
   );

`ifdef SEG_SCAN_LZB_EN
   logic upper_zero;

   // Mark digits k>0 whose nibble and every higher nibble are zero.
   always_comb begin
      lz_mask    = '0;
      upper_zero = 1'b1;
      for (int k = N_DIGITS - 1; k > 0; k--) begin
         upper_zero = upper_zero & (shadow_q[4*k +: 4] == 4'h0);
         lz_mask[k] = upper_zero;
      end
   end
`else
   // Every digit is displayed, leading zeros included.
   always_comb begin
      lz_mask = '0;
   end
`endif

   // Next-state, capture and registered-output values for the scan FSM.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      ack_d    = 1'b0;
      tick_d   = 1'b0;
      seg_d    = SEG_OFF;
      dp_d     = 1'b1;
      an_d     = '1;
      boundary = 1'b0;

      case (state_q)
         ST_IDLE: begin
            idx_d = '0;
            cnt_d = '0;
            if (en) begin
               state_d  = ST_BLANK;
               boundary = 1'b1;
            end else if (value_vld && !ack_q) begin
               shadow_d = value;
               ack_d    = 1'b1;
            end
         end
         ST_BLANK: begin
            if (!en) begin
               state_d = ST_IDLE;
               idx_d   = '0;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == BLANK_LAST) begin
                  state_d = ST_SHOW;
               end
            end
         end
         ST_SHOW: begin
            if (!en) begin
               state_d = ST_IDLE;
               idx_d   = '0;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_BLANK;
               cnt_d   = '0;
               if (idx_q == IDX_LAST) begin
                  idx_d    = '0;
                  boundary = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
         end
      endcase

      // Frame boundary: pulse frame_tick and take any pending offer.
      if (boundary) begin
         tick_d = 1'b1;
         if (value_vld && !ack_q) begin
            shadow_d = value;
            ack_d    = 1'b1;
         end
      end

      // Outputs follow the next state so pins and state move on one edge.
      // idx never changes on an edge that lands in SHOW, so idx_q is current.
      if (state_d == ST_SHOW) begin
         an_d[idx_q] = 1'b0;
         if (lz_mask[idx_q]) begin
            seg_d = SEG_OFF;
            dp_d  = 1'b1;
         end else begin
            seg_d = enc_seg;
            dp_d  = ~dp_in[idx_q];
         end
      end
   end

   // State, shadow and registered pin outputs with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         cnt_q    <= '0;
         shadow_q <= '0;
         ack_q    <= 1'b0;
         tick_q   <= 1'b0;
         seg_q    <= SEG_OFF;
         dp_q     <= 1'b1;
         an_q     <= '1;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         ack_q    <= ack_d;
         tick_q   <= tick_d;
         seg_q    <= seg_d;
         dp_q     <= dp_d;
         an_q     <= an_d;
      end
   end

   assign value_ack  = ack_q;
   assign frame_tick = tick_q;
   assign seg_n      = seg_q;
   assign dp_n       = dp_q;
   assign an_n       = an_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with 4 digits, 20-cycle slots and a
// 4-cycle blank gap. Expected pin values {ack,tick,dp_n,seg_n,an_n} are
// pushed before each clock and popped after it.
module tb_seg_scan_ctrl;

   localparam int NDIG  = 4;
   localparam int SLOT  = 20;
   localparam int BLANK = 4;
   localparam int FRAME = NDIG * SLOT;
   localparam int W     = 14;

   localparam logic [W-1:0] DARK = {1'b0, 1'b0, 1'b1, 7'h7F, 4'hF};

   logic            clk = 1'b0;
   logic            rst_n;
   logic            en;
   logic [15:0]     value;
   logic [3:0]      dp_in;
   logic            value_vld;
   logic            value_ack;
   logic [6:0]      seg_n;
   logic            dp_n;
   logic [3:0]      an_n;
   logic            frame_tick;

   logic [W-1:0]    exp_q[$];
   int              total = 0;
   int              bad   = 0;
   int              t_m;
   logic [15:0]     shadow_m;

   seg_scan_ctrl #(
      .N_DIGITS  (NDIG),
      .SLOT_CYC  (SLOT),
      .BLANK_CYC (BLANK)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .value      (value),
      .dp_in      (dp_in),
      .value_vld  (value_vld),
      .value_ack  (value_ack),
      .seg_n      (seg_n),
      .dp_n       (dp_n),
      .an_n       (an_n),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] glyph(input logic [3:0] h);
      case (h)
         4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;
         4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
         4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;
         4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
         4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;
         4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
         4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;
         4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
      endcase
   endfunction

   // Pin values t cycles after a frame start, from the slot timeline.
   function automatic logic [W-1:0] scan_exp(input int t, input logic [15:0] sh,
                                             input logic [3:0] dp, input logic ack);
      int         d;
      logic [3:0] an;
      logic [6:0] seg;
      logic       dpn;
      logic [3:0] nib;
      d   = (t / SLOT) % NDIG;
      an  = 4'hF;
      seg = 7'h7F;
      dpn = 1'b1;
      nib = 4'(sh >> (4 * d));
      if ((t % SLOT) >= BLANK) begin
         an[d] = 1'b0;
         seg   = glyph(nib);
         dpn   = ~dp[d];
`ifdef SEG_SCAN_LZB_EN
         if (d > 0 && (sh >> (4 * d)) == 16'h0) begin
            seg = 7'h7F;
            dpn = 1'b1;
         end
`endif
      end
      return {ack, (t % FRAME) == 0, dpn, seg, an};
   endfunction

   task automatic check_out(input string tag);
      logic [W-1:0] obs;
      logic [W-1:0] e;
      obs = {value_ack, frame_tick, dp_n, seg_n, an_n};
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL %s: scoreboard empty, observed=%h", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
         end
      end
   endtask

   task automatic step_check(input logic [W-1:0] e, input string tag);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      check_out(tag);
   endtask

   // Advance n scan cycles; a pending offer is taken at the next frame start.
   task automatic scan_cycles(input int n, input string tag);
      logic a;
      for (int i = 0; i < n; i++) begin
         t_m = t_m + 1;
         a = ((t_m % FRAME) == 0) && value_vld;
         if (a) shadow_m = value;
         exp_q.push_back(scan_exp(t_m, shadow_m, dp_in, a));
         @(posedge clk);
         #1;
         check_out(tag);
         if (a) value_vld = 1'b0;
      end
   endtask

   initial begin
      // Reset and idle
      rst_n     = 1'b0;
      en        = 1'b0;
      value     = 16'h0;
      dp_in     = 4'h0;
      value_vld = 1'b0;
      shadow_m  = 16'h0;
      repeat (3) @(posedge clk);
      #1;
      exp_q.push_back(DARK);
      check_out("reset");
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) step_check(DARK, "idle");

      // Capture while idle; vld held high must not give two acks in a row
      value     = 16'h12AF;
      value_vld = 1'b1;
      step_check({1'b1, DARK[W-2:0]}, "idle_ack");
      shadow_m = 16'h12AF;
      step_check(DARK, "ack_not_consec");
      value_vld = 1'b0;
      step_check(DARK, "idle_ack_clr");

      // Scan order with dp on digit 2
      dp_in = 4'b0100;
      en    = 1'b1;
      t_m   = -1;
      scan_cycles(2 * FRAME + 20, "scan");

      // Mid-frame offer waits for the next frame start
      value     = 16'h0009;
      value_vld = 1'b1;
      scan_cycles(100, "frame_atomic");

      // Enable drop in digit 2 SHOW, then restart at digit 0
      scan_cycles(11, "to_digit2");
      en = 1'b0;
      step_check(DARK, "en_drop");
      step_check(DARK, "en_drop_idle");
      en  = 1'b1;
      t_m = -1;
      scan_cycles(30, "reenable");

      // Async reset between edges while digit 1 is lit
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.push_back(DARK);
      check_out("async_rst");
      en       = 1'b0;
      shadow_m = 16'h0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      step_check(DARK, "post_rst_idle");

      // Shadow cleared by reset: all digits read 0
      dp_in = 4'b0001;
      en    = 1'b1;
      t_m   = -1;
      scan_cycles(FRAME, "shadow_zero");

      // Enable and offer together from IDLE: tick and ack on one edge
      en = 1'b0;
      step_check(DARK, "idle_again");
      value     = 16'h3C5E;
      value_vld = 1'b1;
      en        = 1'b1;
      t_m       = -1;
      scan_cycles(FRAME + 5, "en_vld_same");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for an N-digit common-anode seven-segment display. Shares one hex-to-seven-segment encoder across all digits, rotating anode enables at a fixed slot rate with an anti-ghosting blank gap. Captures new display values through a valid/ack handshake, only at frame boundaries, so a frame never shows mixed old and new values. Sits between the register/status logic and the board display pins.

Parameters:
N_DIGITS, 4, number of digits scanned (>=1)
SLOT_CYC, 50000, clock cycles per digit slot, blank gap included
BLANK_CYC, 16, cycles at the start of each slot with all anodes off (1 <= BLANK_CYC < SLOT_CYC)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  scan enable; 0 = display dark
value  in  4*N_DIGITS  hex digits; nibble k drives digit k, digit 0 = least significant
dp_in  in  N_DIGITS  decimal point request per digit, active-high, sampled live
value_vld  in  1  new value offered; held with value stable until value_ack
value_ack  out  1  one-cycle pulse: value captured into shadow register
seg_n  out  7  segments a..g, active-low, registered
dp_n  out  1  decimal point, active-low, registered
an_n  out  N_DIGITS  digit anodes, active-low, one-hot-low or all-high, registered
frame_tick  out  1  one-cycle pulse when digit 0's slot starts

Behaviour:
- Reset values: seg_n=7'h7F, dp_n=1, an_n=all 1, value_ack=0, frame_tick=0, shadow=0, idx=0, slot counter=0, state=IDLE.
- Reset is asynchronous: all outputs go to reset values immediately, mid-frame included.
- States:
  - IDLE: outputs dark. On en=1, go to BLANK with idx=0, counter=0.
  - BLANK: an_n all 1, seg_n=7'h7F, dp_n=1. After BLANK_CYC cycles, go to SHOW.
  - SHOW: an_n[idx]=0, seg_n=enc(shadow[idx]), dp_n=~dp_in[idx]. When the counter reaches SLOT_CYC-1, go to BLANK and set idx=(idx==N_DIGITS-1)?0:idx+1.
- Slot counter: width $clog2(SLOT_CYC). Counts 0..SLOT_CYC-1 across BLANK+SHOW, then clears.
- All outputs are registered. an_n, seg_n and dp_n change on the same edge as the state change. No cycle with an anode on and stale segments.
- Frame boundary is the transition into BLANK with idx=0 (including the IDLE->BLANK transition). On that edge, frame_tick=1.
- Value capture in the scanning states:
  - If value_vld=1 at the frame boundary, shadow<=value and value_ack=1 on the same edge.
  - Otherwise the shadow holds.
- Value capture in IDLE: if value_vld=1, capture next cycle with value_ack=1, so configuration works with the display off.
- value_ack is never asserted on two consecutive cycles. A vld still high after ack is treated as a new offer at the next boundary.
- en=0 in BLANK/SHOW: next edge goes to IDLE, outputs dark. A pending vld is then handled by the IDLE rule.
- en=1 with value_vld=1 arriving from IDLE on the same cycle: capture and frame_tick occur on the same edge.
- N_DIGITS=1: idx stays 0 and every slot is a frame boundary.

Optional Feature:
SEG_SCAN_LZB_EN (leading-zero blanking).
- Defined: any digit k>0 whose nibble and all higher nibbles of the shadow are 0 shows seg_n=7'h7F and dp_n=1 during its SHOW slot. The anode still sequences and timing is unchanged. Digit 0 is always shown.
- Undefined: all digits are displayed, including leading zeros.

Decomposition:
- Shared package seg_pkg: state enum (IDLE, BLANK, SHOW), SEG_OFF=7'h7F constant, the 16-entry active-low hex glyph table (0..F, same encoding the team's existing encoder uses).
- One sub-module: the existing combinational hex-to-seven-segment encoder, instantiated once. Its input is the muxed shadow nibble; its output is registered in this block.

Test Plan:
- Reset/idle: rst_n=0, then 1 with en=0 -> seg_n=7'h7F, an_n=4'hF, value_ack=0 indefinitely.
- Scan order (SLOT_CYC=20, BLANK_CYC=4, value=16'h12AF, en=1):
  - an_n walks E,D,B,7 with 4 dark cycles per slot; frame_tick every 80 cycles.
  - seg_n per digit = 7'h0E, 7'h08, 7'h24, 7'h79.
- Frame-atomic update: offer value=16'h0009 mid-frame -> value_ack is held off until the next frame_tick edge. The remaining digits of the current frame still show the old value.
- Enable drop mid-SHOW of digit 2 -> next edge an_n=4'hF, state IDLE. Re-enable -> scanning restarts at digit 0 with frame_tick.
- Async reset asserted mid-SHOW -> outputs dark without waiting for a clock edge; shadow=0 after release.
- With SEG_SCAN_LZB_EN defined, value=16'h0050: digits 3 and 2 show 7'h7F, digit 1 shows 7'h12, digit 0 shows 7'h40. Also value=16'h0000: only digit 0 lit, showing 7'h40.
